// File: rtl/ddr_cal_pkg.sv
// Shared types and timing defaults for the DDR calibration sequencer.
// State encoding, training pattern and helper used by ddr_cal_seq.
package ddr_cal_pkg;

  typedef enum logic [3:0] {
    Idle   = 4'd0,
    Write  = 4'd1,
    WHold  = 4'd2,
    Start  = 4'd3,
    Read   = 4'd4,
    RGap   = 4'd5,
    Settle = 4'd6,
    Check  = 4'd7,
    Done   = 4'd8,
    Fail   = 4'd9
  } calState_t;

  localparam logic [7:0] CAL_PATTERN = 8'hAA;

  localparam int DEF_NBANKS  = 6;
  localparam int DEF_NREADS  = 64;
  localparam int DEF_RD_GAP  = 8;
  localparam int DEF_WR_HOLD = 12;
  localparam int DEF_SETTLE  = 160;
  localparam int DEF_TIMEOUT = 1023;

  function automatic int imax(
    input int a,
    input int b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cal_timer.sv
// Loadable down-counter with zero flag; holds at zero.
// Ports: MCLK90, M90ResetL, load/loadVal, dec, zero.
module cal_timer #(
  parameter int W = 11
) (
  input  logic         MCLK90,
  input  logic         M90ResetL,
  input  logic         load,
  input  logic [W-1:0] loadVal,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge MCLK90) begin
    if (!M90ResetL) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= loadVal;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/ddr_cal_seq.sv
// DDR calibration sequencer: training write, DQ cal start, read sweep,
// settle, bank fail check. Ports: MCLK90/M90ResetL, CalGo, CmdAck,
// BankCalFail in; CalWrReq/CalRdReq, ForceA, StartDQCal, CalBusy,
// CalDone, CalError, FailMask, TimedOut out.
module ddr_cal_seq
  import ddr_cal_pkg::*;
#(
  parameter int NBANKS  = DEF_NBANKS,
  parameter int NREADS  = DEF_NREADS,
  parameter int RD_GAP  = DEF_RD_GAP,
  parameter int WR_HOLD = DEF_WR_HOLD,
  parameter int SETTLE  = DEF_SETTLE,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              MCLK90,
  input  logic              M90ResetL,
  input  logic              CalGo,
  input  logic              CmdAck,
  input  logic [NBANKS-1:0] BankCalFail,
  output logic              CalWrReq,
  output logic              CalRdReq,
  output logic              ForceA,
  output logic              StartDQCal,
  output logic              CalBusy,
  output logic              CalDone,
  output logic              CalError,
  output logic [NBANKS-1:0] FailMask,
  output logic              TimedOut
);

  localparam int TMAX = imax(imax(TIMEOUT, SETTLE),
                             imax(WR_HOLD, RD_GAP));
  localparam int TW = $clog2(TMAX) + 1;
  localparam int RW = $clog2(NREADS + 1);

  calState_t state, nxt;

  logic [RW-1:0] rdCnt;
  logic [TW-1:0] tVal;
  logic          tLoad;
  logic          tZero;
  logic          doClear;
  logic          doTimeout;
  logic          rdAck;

  cal_timer #(
    .W(TW)
  ) uTimer (
    .MCLK90   (MCLK90),
    .M90ResetL(M90ResetL),
    .load     (tLoad),
    .loadVal  (tVal),
    .dec      (1'b1),
    .zero     (tZero)
  );

  // Ack is checked before the timer so a late ack still counts.
  always_comb begin
    nxt       = state;
    doClear   = 1'b0;
    doTimeout = 1'b0;
    rdAck     = 1'b0;
    unique case (state)
      Idle, Done, Fail: begin
        if (CalGo) begin
          nxt     = Write;
          doClear = 1'b1;
        end
      end
      Write: begin
        if (CmdAck) begin
          nxt = WHold;
        end else if (tZero) begin
          nxt       = Fail;
          doTimeout = 1'b1;
        end
      end
      WHold: begin
        if (tZero) nxt = Start;
      end
      Start: begin
        nxt = Read;
      end
      Read: begin
        if (CmdAck) begin
          rdAck = 1'b1;
          if ((rdCnt + 1'b1) == RW'(NREADS))
            nxt = Settle;
          else
            nxt = RGap;
        end else if (tZero) begin
          nxt       = Fail;
          doTimeout = 1'b1;
        end
      end
      RGap: begin
        if (tZero) nxt = Read;
      end
      Settle: begin
        if (tZero) nxt = Check;
      end
      Check: begin
        nxt = (|BankCalFail) ? Fail : Done;
      end
      default: begin
        nxt = Idle;
      end
    endcase
  end

  // Timer reloads on every state change, with the new state's length.
  always_comb begin
    tLoad = (nxt != state);
    tVal  = '0;
    unique case (nxt)
      Write, Read: tVal = TW'(TIMEOUT - 1);
      WHold:       tVal = TW'(WR_HOLD - 1);
      RGap:        tVal = TW'(RD_GAP - 1);
      Settle:      tVal = TW'(SETTLE - 1);
      default:     tVal = '0;
    endcase
  end

  always_ff @(posedge MCLK90) begin
    if (!M90ResetL) begin
      state    <= Idle;
      rdCnt    <= '0;
      CalDone  <= 1'b0;
      CalError <= 1'b0;
      TimedOut <= 1'b0;
      FailMask <= '0;
    end else begin
      state <= nxt;
      if (state == Start) begin
        rdCnt <= '0;
      end else if (rdAck) begin
        rdCnt <= rdCnt + 1'b1;
      end
      if (doClear) begin
        CalDone  <= 1'b0;
        CalError <= 1'b0;
        TimedOut <= 1'b0;
        FailMask <= '0;
      end
      if (state == Check) begin
        FailMask <= BankCalFail;
        CalError <= |BankCalFail;
        CalDone  <= ~|BankCalFail;
      end
      if (doTimeout) begin
        TimedOut <= 1'b1;
        CalError <= 1'b1;
        FailMask <= '1;
      end
    end
  end

  assign CalWrReq   = (state == Write);
  assign CalRdReq   = (state == Read);
  assign ForceA     = (state == Write) || (state == WHold);
  assign StartDQCal = (state == Start);
  assign CalBusy    = !((state == Idle) || (state == Done) ||
                        (state == Fail));

endmodule

// File: tb/tb_ddr_cal_seq.sv
// Randomized bench for ddr_cal_seq: scheduler model with random ack
// latency, transaction-level expectations per calibration run.
module tb_ddr_cal_seq;
  import ddr_cal_pkg::*;

  localparam int NB   = 6;
  localparam int NR   = 64;
  localparam int GAP  = 8;
  localparam int HOLD = 12;
  localparam int SET  = 160;
  localparam int TO   = 1023;

  logic          MCLK90 = 1'b0;
  logic          M90ResetL = 1'b0;
  logic          CalGo = 1'b0;
  logic          CmdAck = 1'b0;
  logic [NB-1:0] BankCalFail = '0;
  logic          CalWrReq, CalRdReq, ForceA, StartDQCal;
  logic          CalBusy, CalDone, CalError, TimedOut;
  logic [NB-1:0] FailMask;

  int errs = 0;
  int checks = 0;

  ddr_cal_seq #(
    .NBANKS(NB), .NREADS(NR), .RD_GAP(GAP),
    .WR_HOLD(HOLD), .SETTLE(SET), .TIMEOUT(TO)
  ) dut (
    .MCLK90     (MCLK90),
    .M90ResetL  (M90ResetL),
    .CalGo      (CalGo),
    .CmdAck     (CmdAck),
    .BankCalFail(BankCalFail),
    .CalWrReq   (CalWrReq),
    .CalRdReq   (CalRdReq),
    .ForceA     (ForceA),
    .StartDQCal (StartDQCal),
    .CalBusy    (CalBusy),
    .CalDone    (CalDone),
    .CalError   (CalError),
    .FailMask   (FailMask),
    .TimedOut   (TimedOut)
  );

  always #5 MCLK90 = ~MCLK90;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               tag, got, got, exp, exp);
    end
  endtask

  function automatic logic [31:0] allOut();
    return {CalWrReq, CalRdReq, ForceA, StartDQCal, CalBusy,
            CalDone, CalError, TimedOut, 8'(FailMask)};
  endfunction

  // One calibration run. lat=0 means random ack latency 1..6.
  // stallRd/raceRd/rstRd index a read (0-based), -1 disables.
  task automatic runCal(input string nm, input int lat,
                        input int failAt, input logic [NB-1:0] mask,
                        input int stallRd, input int raceRd,
                        input int rstRd, input bit spur);
    int wrAcks = 0, rdAcks = 0, age = 0, myLat = 0, want = 0;
    int holdCnt = 0, starts = 0, startForce = 0, both = 0;
    int lowCnt = 0, gapErr = 0, since = 0, doneDly = -1;
    int dropLen = -1, cyc = 0, fwErr = 0;
    bit wrAcked = 0, rdSeen = 0, spurDone = 0, finished = 0;
    bit rstHit = 0;
    logic prevRd = 1'b0;
    bit expTo, expErr;
    logic [NB-1:0] expMask;

    myLat = (lat != 0) ? lat : int'($urandom_range(1, 6));
    @(negedge MCLK90);
    CalGo = 1'b1;
    CmdAck = 1'b0;
    BankCalFail = '0;
    while (!finished && cyc < 6000) begin
      @(negedge MCLK90);
      cyc++;
      CmdAck = 1'b0;
      if (CalWrReq && CalRdReq) both++;
      if (CalWrReq && !ForceA) fwErr++;
      if (StartDQCal) begin
        starts++;
        if (ForceA) startForce++;
      end
      if (wrAcked && ForceA) holdCnt++;
      if (rdSeen) since++;
      if (CalRdReq && !prevRd && rdSeen && lowCnt != GAP) gapErr++;
      if (!CalRdReq && rdSeen) lowCnt++;
      prevRd = CalRdReq;
      if (CalDone || CalError) begin
        doneDly = since;
        finished = 1;
      end
      if (!(CalWrReq || CalRdReq) && age > 0) begin
        dropLen = age;
        age = 0;
      end
      if (CalWrReq || CalRdReq) begin
        age++;
        if (rstRd >= 0 && CalRdReq && rdAcks == rstRd && age == 1) begin
          M90ResetL = 1'b0;
          CalGo = 1'b0;
          @(negedge MCLK90);
          chk({nm, ".rstOuts"}, allOut(), 0);
          M90ResetL = 1'b1;
          repeat (3) @(negedge MCLK90);
          chk({nm, ".rstIdle"}, allOut(), 0);
          rstHit = 1;
          finished = 1;
        end else begin
          want = (CalRdReq && rdAcks == raceRd) ? TO : myLat;
          if (!(CalRdReq && rdAcks == stallRd) && age == want) begin
            CmdAck = 1'b1;
            age = 0;
            if (CalWrReq) begin
              wrAcks++;
              wrAcked = 1;
            end else begin
              rdAcks++;
              rdSeen = 1;
              since = 0;
              lowCnt = 0;
            end
            myLat = (lat != 0) ? lat : int'($urandom_range(1, 6));
          end
        end
      end
      if (spur && !spurDone && rdAcks == 10 && !CalRdReq && lowCnt == 3)
      begin
        CmdAck = 1'b1;
        spurDone = 1;
      end
      BankCalFail = (failAt >= 0 && rdAcks >= failAt) ? mask : '0;
      if (!finished && rdAcks >= 1 && rdAcks < 10 && stallRd < 0)
        CalGo = 1'($urandom_range(0, 1));
      else
        CalGo = 1'b0;
    end
    CmdAck = 1'b0;
    CalGo = 1'b0;
    if (rstHit) begin
      chk({nm, ".rstRdAcks"}, rdAcks, rstRd);
    end else begin
      expTo = (stallRd >= 0);
      expErr = expTo || (failAt >= 0 && mask != '0);
      expMask = expTo ? '1 : ((failAt >= 0) ? mask : '0);
      chk({nm, ".finished"}, finished, 1);
      chk({nm, ".bothReq"}, both, 0);
      chk({nm, ".forceWr"}, fwErr, 0);
      chk({nm, ".wrAcks"}, wrAcks, 1);
      chk({nm, ".starts"}, starts, 1);
      chk({nm, ".startForce"}, startForce, 0);
      chk({nm, ".holdCycles"}, holdCnt, HOLD);
      chk({nm, ".gapErr"}, gapErr, 0);
      chk({nm, ".rdAcks"}, rdAcks, expTo ? stallRd : NR);
      chk({nm, ".TimedOut"}, TimedOut, expTo);
      chk({nm, ".CalError"}, CalError, expErr);
      chk({nm, ".CalDone"}, CalDone, !expErr);
      chk({nm, ".FailMask"}, FailMask, expMask);
      if (expTo) chk({nm, ".dropLen"}, dropLen, TO);
      else chk({nm, ".doneDly"}, doneDly, SET + 2);
      repeat (5) @(negedge MCLK90);
      chk({nm, ".holdOuts"}, allOut(),
          {8'b0, CalDone && !expErr, expErr, expTo, 8'(expMask)});
    end
  endtask

  initial begin
    int r;
    M90ResetL = 1'b0;
    repeat (3) @(negedge MCLK90);
    chk("reset.outs", allOut(), 0);
    M90ResetL = 1'b1;
    CmdAck = 1'b1;
    @(negedge MCLK90);
    CmdAck = 1'b0;
    repeat (2) @(negedge MCLK90);
    chk("idle.ackIgnored", allOut(), 0);

    runCal("nominal", 3, -1, '0, -1, -1, -1, 0);
    runCal("bankFail", 3, 20, 6'b000100, -1, -1, -1, 0);
    r = int'($urandom_range(0, NR - 1));
    runCal("randFail", 0, r, NB'($urandom_range(1, 63)), -1, -1, -1, 0);
    runCal("timeout", 0, -1, '0, 4, -1, -1, 0);
    runCal("race", 0, -1, '0, -1, 20, -1, 1);
    runCal("rstMid", 0, -1, '0, -1, -1, 29, 0);
    runCal("afterRst", 0, -1, '0, -1, -1, -1, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ddr_cal_seq.md
Name: ddr_cal_seq

Overview:
- Central calibration sequencer on MCLK90, directly upstream of the 6 x72 ECC RDIMM I/O banks (12 DQ each).
- Writes the 0xAA training pattern, pulses StartDQCal, then issues exactly NREADS read bursts so every bank's per-lane delay calibrator can sweep its taps.
- Waits for the banks to settle, collects their CalFail flags and reports done/fail to the main controller.
- Issues bursts through a req/ack handshake to the command scheduler, which produces the timed WriteBurst/ReadBurst strobes.

Parameters:
- NBANKS, 6, number of I/O banks served.
- NREADS, 64, calibration reads issued; equals the tap count swept per bank.
- RD_GAP, 8, idle MCLK90 cycles after each read ack before the next read request.
- WR_HOLD, 12, cycles ForceA stays high after write ack (covers write-data pipeline).
- SETTLE, 160, cycles waited after the last read ack (covers bank DecWS/DecWW tap walk, at most 2*NREADS+margin).
- TIMEOUT, 1023, maximum cycles to wait for CmdAck.

Ports:
- MCLK90  in  1  clock; all logic on its rising edge.
- M90ResetL  in  1  synchronous active-low reset.
- CalGo  in  1  level; start calibration when high in Idle or Done.
- CmdAck  in  1  one-cycle pulse; scheduler accepted the pending request.
- BankCalFail  in  NBANKS  CalFail outputs of the banks.
- CalWrReq  out  1  request one training write burst.
- CalRdReq  out  1  request one calibration read burst.
- ForceA  out  1  to all banks; force 0xAA write data.
- StartDQCal  out  1  to all banks; one-cycle start pulse.
- CalBusy  out  1  high from leaving Idle until Done/Fail.
- CalDone  out  1  sticky; calibration passed.
- CalError  out  1  sticky; calibration failed.
- FailMask  out  NBANKS  latched BankCalFail at check, all-ones on timeout.
- TimedOut  out  1  sticky; failure caused by missing CmdAck.

Behaviour:
- Reset (M90ResetL low at an edge): state Idle, all outputs 0, all counters 0. Reset mid-operation aborts immediately; no request stays asserted the cycle after.
- Requests are level-held: CalWrReq/CalRdReq high until the cycle CmdAck is sampled high, then low the next cycle. Never both high. CmdAck while no request is pending is ignored.
- States:
  - Idle: CalGo=1 -> Write; clear CalDone, CalError, TimedOut, FailMask. Same from Done/Fail.
  - Write: ForceA=1, CalWrReq=1; on CmdAck -> WHold.
  - WHold: ForceA=1 for WR_HOLD cycles -> Start.
  - Start: StartDQCal=1 for exactly one cycle, ForceA=0; RdCnt<=0 -> Read.
  - Read: CalRdReq=1; on CmdAck RdCnt+1. If new count == NREADS -> Settle, else -> RGap.
  - RGap: RD_GAP cycles -> Read.
  - Settle: SETTLE cycles -> Check.
  - Check (1 cycle): FailMask<=BankCalFail. Any bit set -> Fail (CalError=1), else -> Done (CalDone=1).
  - Done/Fail: hold; CalBusy=0.
- Timeout: a cycle counter runs while a request is pending. Reaching TIMEOUT -> Fail, TimedOut=1, CalError=1, FailMask all ones, request dropped.
- Counters: RdCnt clog2(NREADS+1) bits, no wrap. Gap/settle/timeout counter shared, clog2(max)+1 bits, reloaded on each state entry.
- CmdAck in the same cycle a timeout expires: ack wins, no timeout.
- CalGo high in any other state is ignored. CalGo still high on entering Done restarts calibration immediately (documented re-cal behaviour).
- BankCalFail is sampled only in Check; earlier assertion does not abort, because all banks share the reads.

Decomposition:
- Shared package ddr_cal_pkg: state encoding localparams (Idle, Write, WHold, Start, Read, RGap, Settle, Check, Done, Fail), 0xAA pattern constant, default timing constants.
- One natural sub-module: cal_timer, a loadable down-counter with a zero flag, used for the gap, settle, hold and timeout counts.

Test Plan:
- Nominal: CalGo=1, scheduler acks each request after 3 cycles, BankCalFail=0 -> 1 write, then StartDQCal one cycle, 64 CalRdReq handshakes each 8+ cycles apart, CalDone=1 after SETTLE, FailMask=0.
- Bank failure: as nominal, BankCalFail=6'b000100 from read 20 on -> CalError=1, FailMask=6'b000100, CalDone=0.
- Timeout: never ack the 5th read -> CalRdReq drops after 1023 cycles, TimedOut=1, CalError=1, FailMask=6'b111111, RdCnt frozen at 4.
- Ack/timeout race: ack exactly at timeout expiry -> read counted, no TimedOut.
- Reset mid-read (read 30): all outputs 0 next cycle, state Idle. Then CalGo -> full clean sequence of 64 reads.
- ForceA window: ForceA high from the write request through WR_HOLD=12 cycles after ack, low before the StartDQCal pulse. A spurious CmdAck in RGap is ignored (read count unchanged).
